// File: rtl/mini_alu_pkg.sv
// mini_alu_pkg: shared widths, command record and sequencer states for the mini ALU controller.
// The command record carries a chain bit only when MINI_ALU_SEQ_CHAIN_EN is defined.
package mini_alu_pkg;
    localparam int OP_W = 4;
    localparam int RES_W = 20;
    typedef struct packed {
`ifdef MINI_ALU_SEQ_CHAIN_EN
        logic chain;
`endif
        logic [OP_W-1:0] op1;
        logic [OP_W-1:0] op2;
        logic operation;
        logic sign;
    } alu_cmd_t;
    typedef enum logic [1:0] {IDLE, DRIVE, RESP} seq_state_t;
endpackage

// File: rtl/mini_alu_cmd_fifo.sv
// mini_alu_cmd_fifo: synchronous FIFO of ALU commands with full, empty and occupancy outputs.
// Pushes into a full FIFO and pops from an empty one are ignored.
module mini_alu_cmd_fifo
    import mini_alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  alu_cmd_t                 wdata,
    input  logic                     pop,
    output alu_cmd_t                 rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    alu_cmd_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign rdata = mem[rptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
    // Pointers are exactly log2(DEPTH) wide, so wrapping is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= do_push ? wptr + 1'b1 : wptr;
            rptr <= do_pop ? rptr + 1'b1 : rptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mini_alu_seq.sv
// mini_alu_seq: queues ALU commands, issues them one at a time and returns each result over a handshake.
// Define MINI_ALU_SEQ_CHAIN_EN to add cmd_chain, which feeds the previous result into op1.
module mini_alu_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int OP_W = 4,
    parameter int RES_W = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [OP_W-1:0]               cmd_op1,
    input  logic [OP_W-1:0]               cmd_op2,
    input  logic                          cmd_operation,
    input  logic                          cmd_sign,
`ifdef MINI_ALU_SEQ_CHAIN_EN
    input  logic                          cmd_chain,
`endif
    output logic [OP_W-1:0]               alu_op1,
    output logic [OP_W-1:0]               alu_op2,
    output logic                          alu_operation,
    output logic                          alu_sign,
    input  logic [RES_W-1:0]              alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [RES_W-1:0]              rsp_result,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    import mini_alu_pkg::*;
    seq_state_t state;
    alu_cmd_t wcmd, head;
    logic full, empty, pop;
    always_comb begin
        wcmd.op1 = cmd_op1;
        wcmd.op2 = cmd_op2;
        wcmd.operation = cmd_operation;
        wcmd.sign = cmd_sign;
`ifdef MINI_ALU_SEQ_CHAIN_EN
        wcmd.chain = cmd_chain;
`endif
    end
    assign cmd_ready = !full;
    assign pop = state == IDLE && !empty;
    assign busy = state != IDLE || !empty;
    mini_alu_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid),
        .wdata (wcmd),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            alu_op1 <= '0;
            alu_op2 <= '0;
            alu_operation <= 1'b0;
            alu_sign <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_result <= '0;
        end else begin
            case (state)
                IDLE: if (pop) begin
`ifdef MINI_ALU_SEQ_CHAIN_EN
                    // rsp_result keeps the last completed result, so it doubles as the chain source.
                    alu_op1 <= head.chain ? rsp_result[OP_W-1:0] : head.op1;
`else
                    alu_op1 <= head.op1;
`endif
                    alu_op2 <= head.op2;
                    alu_operation <= head.operation;
                    alu_sign <= head.sign;
                    state <= DRIVE;
                end
                DRIVE: begin
                    rsp_result <= alu_result;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mini_alu_seq.sv
// tb_mini_alu_seq: directed self-checking bench for mini_alu_seq with a behavioural mini ALU stub.
// Covers the chain feature too when MINI_ALU_SEQ_CHAIN_EN is defined.
module tb_mini_alu_seq;
    localparam int FIFO_DEPTH = 4;
    localparam int OP_W = 4;
    localparam int RES_W = 20;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [OP_W-1:0] cmd_op1 = '0, cmd_op2 = '0;
    logic cmd_operation = 1'b0, cmd_sign = 1'b0;
    logic cmd_chain = 1'b0;
    logic [OP_W-1:0] alu_op1, alu_op2;
    logic alu_operation, alu_sign;
    logic [RES_W-1:0] alu_result;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [RES_W-1:0] rsp_result;
    logic busy;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    int checks = 0;
    int failures = 0;
    logic [RES_W-1:0] exp_q[$];
    always #5 clk = ~clk;
    assign alu_result = alu_operation
        ? (alu_sign ? RES_W'(alu_op1) >> alu_op2 : RES_W'(alu_op1) << alu_op2)
        : (alu_sign ? RES_W'(alu_op1) - RES_W'(alu_op2) : RES_W'(alu_op1) + RES_W'(alu_op2));
    mini_alu_seq #(.FIFO_DEPTH(FIFO_DEPTH), .OP_W(OP_W), .RES_W(RES_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op1       (cmd_op1),
        .cmd_op2       (cmd_op2),
        .cmd_operation (cmd_operation),
        .cmd_sign      (cmd_sign),
`ifdef MINI_ALU_SEQ_CHAIN_EN
        .cmd_chain     (cmd_chain),
`endif
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_operation (alu_operation),
        .alu_sign      (alu_sign),
        .alu_result    (alu_result),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic set_cmd(input logic [3:0] a, input logic [3:0] b, input logic op, input logic sg);
        cmd_op1 = a;
        cmd_op2 = b;
        cmd_operation = op;
        cmd_sign = sg;
    endtask
    task automatic push(input logic [3:0] a, input logic [3:0] b, input logic op, input logic sg,
                        input logic [19:0] e);
        set_cmd(a, b, op, sg);
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !cmd_ready; i++) step();
        check("push_ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        exp_q.push_back(e);
    endtask
    task automatic get_rsp(input string tag);
        logic [19:0] e;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && !rsp_valid; i++) step();
        e = exp_q.size() > 0 ? exp_q.pop_front() : 20'hBAD00;
        check($sformatf("%s_valid", tag), 32'(rsp_valid), 1);
        check(tag, 32'(rsp_result), 32'(e));
        step();
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
    initial begin
        int seen;
        step();
        step();
        rst = 1'b0;
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_alu_op1", 32'(alu_op1), 0);
        // latency: accepted at edge N, DRIVE after N+1, rsp_valid after N+2
        rsp_ready = 1'b1;
        set_cmd(4'd3, 4'd5, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("lat_count", 32'(fifo_count), 1);
        check("lat_busy", 32'(busy), 1);
        check("lat_n_valid", 32'(rsp_valid), 0);
        step();
        check("lat_drive_op1", 32'(alu_op1), 3);
        check("lat_drive_op2", 32'(alu_op2), 5);
        check("lat_n1_valid", 32'(rsp_valid), 0);
        step();
        check("lat_n2_valid", 32'(rsp_valid), 1);
        check("lat_result", 32'(rsp_result), 32'h00008);
        step();
        check("lat_done_valid", 32'(rsp_valid), 0);
        check("lat_done_busy", 32'(busy), 0);
        check("lat_hold_op1", 32'(alu_op1), 3);
        // ordered vectors
        rsp_ready = 1'b0;
        push(4'd3, 4'd5, 1'b0, 1'b1, 20'hFFFFE);
        push(4'd1, 4'd15, 1'b1, 1'b0, 20'h08000);
        push(4'd8, 4'd2, 1'b1, 1'b1, 20'h00002);
        push(4'd15, 4'd15, 1'b0, 1'b0, 20'h0001E);
        for (int i = 0; i < 4; i++) get_rsp($sformatf("vec%0d", i));
        // stall with a full FIFO
        rsp_ready = 1'b0;
        push(4'd1, 4'd2, 1'b0, 1'b0, 20'h00003);
        push(4'd7, 4'd9, 1'b0, 1'b0, 20'h00010);
        push(4'd0, 4'd1, 1'b0, 1'b1, 20'hFFFFF);
        push(4'd15, 4'd3, 1'b1, 1'b0, 20'h00078);
        push(4'd15, 4'd1, 1'b1, 1'b1, 20'h00007);
        set_cmd(4'd2, 4'd2, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_cmd_ready", 32'(cmd_ready), 0);
            check("stall_count", 32'(fifo_count), 4);
            check("stall_valid", 32'(rsp_valid), 1);
            check("stall_result", 32'(rsp_result), 32'h00003);
        end
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) get_rsp($sformatf("stall%0d", i));
        // pop from full FIFO while a push is offered
        rsp_ready = 1'b0;
        push(4'd2, 4'd3, 1'b0, 1'b0, 20'h00005);
        push(4'd4, 4'd4, 1'b0, 1'b0, 20'h00008);
        push(4'd9, 4'd1, 1'b0, 1'b1, 20'h00008);
        push(4'd3, 4'd2, 1'b1, 1'b0, 20'h0000C);
        push(4'd12, 4'd3, 1'b1, 1'b1, 20'h00001);
        check("wrap_head", 32'(rsp_result), 32'(exp_q.pop_front()));
        set_cmd(4'd6, 4'd6, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("wrap_idle_ready", 32'(cmd_ready), 0);
        check("wrap_idle_count", 32'(fifo_count), 4);
        step();
        check("wrap_pop_count", 32'(fifo_count), 3);
        check("wrap_pop_ready", 32'(cmd_ready), 1);
        step();
        cmd_valid = 1'b0;
        exp_q.push_back(20'h0000C);
        check("wrap_push_count", 32'(fifo_count), 4);
        check("wrap_push_ready", 32'(cmd_ready), 0);
        for (int i = 0; i < 5; i++) get_rsp($sformatf("wrap%0d", i));
        // reset while DRIVE with three queued
        rsp_ready = 1'b0;
        push(4'd1, 4'd1, 1'b0, 1'b0, 20'h00002);
        push(4'd5, 4'd6, 1'b0, 1'b0, 20'h0000B);
        push(4'd5, 4'd6, 1'b0, 1'b1, 20'hFFFFF);
        push(4'd1, 4'd4, 1'b1, 1'b0, 20'h00010);
        push(4'd7, 4'd7, 1'b0, 1'b0, 20'h0000E);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        check("mid_drive_count", 32'(fifo_count), 3);
        check("mid_drive_op2", 32'(alu_op2), 6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(fifo_count), 0);
        check("mid_rst_valid", 32'(rsp_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_alu", {alu_op1, alu_op2, 6'd0, alu_operation, alu_sign}, 0);
        check("mid_rst_ready", 32'(cmd_ready), 1);
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (rsp_valid || busy) seen++;
        end
        check("mid_rst_no_stale", 32'(seen), 0);
`ifdef MINI_ALU_SEQ_CHAIN_EN
        rsp_ready = 1'b0;
        cmd_chain = 1'b0;
        push(4'd2, 4'd3, 1'b0, 1'b0, 20'h00005);
        cmd_chain = 1'b1;
        push(4'd9, 4'd1, 1'b1, 1'b0, 20'h0000A);
        cmd_chain = 1'b0;
        get_rsp("chain0");
        get_rsp("chain1");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mini_alu_seq.md
Name: mini_alu_seq

Overview:
- Sequencing controller for the 4-bit combinational mini ALU (add/sub/shift, 20-bit result).
- Accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time to the ALU through registered drive signals, captures the 20-bit result, and returns it over a valid/ready response handshake.
- Sits between a command source (test harness or small host FSM) and the mini ALU instance.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
- OP_W, 4, operand width; matches ALU operands.
- RES_W, 20, result width; matches ALU result.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_op1  in  OP_W  first operand.
- cmd_op2  in  OP_W  second operand / shift amount.
- cmd_operation  in  1  0 arithmetic, 1 shift.
- cmd_sign  in  1  0 add / left shift, 1 sub / right shift.
- alu_op1  out  OP_W  registered drive to ALU.
- alu_op2  out  OP_W  registered drive to ALU.
- alu_operation  out  1  registered drive to ALU.
- alu_sign  out  1  registered drive to ALU.
- alu_result  in  RES_W  combinational ALU result.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  RES_W  captured result; held stable while rsp_valid && !rsp_ready.
- busy  out  1  FSM not IDLE or FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears:
  - FIFO pointers and fifo_count to 0; stored entries become don't-care.
  - FSM to IDLE.
  - alu_op1, alu_op2, alu_operation, alu_sign, rsp_valid and rsp_result to 0.
  - Consequences: cmd_ready=1 and busy=0 after reset.
- Reset mid-operation discards the in-flight command and all queued commands; no response is emitted for them.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - Pop only by the FSM in IDLE.
  - Simultaneous push and pop: count unchanged, pointers advance, both pointers wrap modulo FIFO_DEPTH.
  - No bypass: a command pushed in cycle N is not visible to the FSM before cycle N+1.
  - cmd_ready is low while full, even if a pop happens that cycle.
- FSM states IDLE, DRIVE, RESP:
  - IDLE: if FIFO not empty, pop the head, load alu_* registers, go to DRIVE; else stay.
  - DRIVE: alu_* registers are stable; at the end of the cycle register alu_result into rsp_result, set rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid and rsp_result. When rsp_ready=1, clear rsp_valid and go to IDLE. No pop occurs in the same cycle (one-cycle IDLE bubble).
- Latency: a command accepted at edge N produces rsp_valid=1 in cycle N+3 (min). Back-to-back throughput is one result per 3 cycles.
- Ordering: strictly FIFO; exactly one response per accepted command.
- alu_* registers hold the last issued command until the next pop.
- Width rules: results are whatever the ALU returns (20-bit wrap on subtract, e.g. 3-5 = 0xFFFFE). The controller does no arithmetic.
- rsp_ready asserted while rsp_valid=0 is ignored.

Optional Feature:
- Macro MINI_ALU_SEQ_CHAIN_EN.
- When defined:
  - Adds input cmd_chain (1 bit), stored per FIFO entry.
  - On pop with cmd_chain=1, alu_op1 is loaded from rsp_result[OP_W-1:0] of the most recently completed command instead of cmd_op1.
  - The chain source resets to 0.
- When undefined: the port is absent, cmd_op1 is always used, and the FIFO entry width excludes the bit.

Decomposition:
- Package mini_alu_pkg:
  - OP_W and RES_W constants.
  - alu_cmd_t packed struct: op1, op2, operation, sign, plus chain under the macro.
  - seq_state_t enum: IDLE, DRIVE, RESP.
- Sub-module mini_alu_cmd_fifo: parameterised synchronous FIFO of alu_cmd_t with full, empty and count outputs.

Test Plan:
- Reset, then push {op1=3, op2=5, op=0, sign=0} at edge N -> rsp_valid first high in cycle N+3, rsp_result=0x00008, alu_op1=3 and alu_op2=5 during DRIVE.
- Push {3,5,0,1} -> rsp_result=0xFFFFE. Push {1,15,1,0} -> 0x08000. Push {8,2,1,1} -> 0x00002. Responses arrive in push order.
- Hold rsp_ready=0 and stream 6 commands -> 5 accepted (1 in flight + 4 queued), cmd_ready=0 and fifo_count=4. Release rsp_ready -> 5 responses in order, rsp_result stable while stalled.
- Assert rst in DRIVE with 3 commands queued -> next cycle fifo_count=0, rsp_valid=0, busy=0, all alu_* = 0; no stale responses afterwards.
- Push at the same edge the FSM pops from a full FIFO -> cmd_ready stays low that cycle, count is correct, and pointers wrap past index FIFO_DEPTH-1 without loss.
- With CHAIN_EN: {2,3,0,0} then {x,1,1,0,chain=1} -> responses 0x00005 then 0x0000A.
